alu_cmd_seq: RTL and testbench
==============================

ALU_CMD_SEQ -- requirements
Module: alu_cmd_seq

Interface
REQ-001 Parameter: FIFO_DEPTH, 4, command FIFO entries (power of two, >=2).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: cmd_valid  input  1  upstream command present.
REQ-005 Port: cmd_ready  output  1  command accepted on edge when cmd_valid && cmd_ready.
REQ-006 Port: cmd_a, cmd_b  input  4 each  operands.
REQ-007 Port: cmd_sel  input  4  opcode.
REQ-008 Port: alu_a, alu_b, alu_sel  output  4 each  registered drive to the 4-bit ALU A, B, ALU_Sel.
REQ-009 Port: alu_out  input  4  ALU result (combinational from alu_a/alu_b/alu_sel).
REQ-010 Port: alu_carry  input  1  ALU carry-out.
REQ-011 Port: res_valid  output  1  result available.
REQ-012 Port: res_ready  input  1  downstream accepts result on edge when res_valid && res_ready.
REQ-013 Port: res_data  output  4  captured result.
REQ-014 Port: res_carry, res_err  output  1 each  carry flag, divide-by-zero flag.
REQ-015 Port: res_sel  output  4  opcode of the result.
REQ-016 Port: busy  output  1  high when FSM not IDLE or FIFO non-empty.

Function
REQ-017 Opcodes: ADD 0, SUB 1, MUL 2, DIV 3, LSL 4, LSR 5, ROL 6, ROR 7, AND 8, OR 9, XOR 10, NOR 11, NAND 12, XNOR 13, GT 14, EQ 15.
REQ-018 cmd_ready = FIFO not full; no bypass, a pop in the same cycle does not raise cmd_ready while full.
REQ-019 FSM states IDLE, DRIVE, HOLD; IDLE->DRIVE when FIFO non-empty (pop, load alu_a/alu_b/alu_sel).
REQ-020 DRIVE->HOLD unconditionally after one cycle; on that edge capture alu_out, alu_carry, alu_sel into res_*; set res_valid.
REQ-021 HOLD: res_* held stable while res_valid && !res_ready.
REQ-022 HOLD on handshake: FIFO non-empty -> pop, reload alu regs, go DRIVE, res_valid=0; else -> IDLE, res_valid=0.
REQ-023 Latency: command accepted at edge N into empty FIFO with FSM IDLE -> res_valid high after edge N+2; peak throughput one result per 2 cycles.
REQ-024 res_carry = alu_carry only when captured opcode is ADD, else 0.
REQ-025 DIV with alu_b = 0: res_err=1, res_data=0, res_carry=0; all other cases res_err=0.
REQ-026 alu_a/alu_b/alu_sel retain last loaded value in IDLE/HOLD.
REQ-027 Results emerge in command acceptance order; no command dropped or duplicated.
REQ-028 FIFO pointers wrap modulo FIFO_DEPTH; simultaneous push and pop with FIFO non-full/non-empty leaves count unchanged.

Reset
REQ-029 rst_n low: FSM IDLE, FIFO empty, all outputs 0 (cmd_ready 0 while rst_n low, 1 from first cycle after release).
REQ-030 Reset mid-operation discards in-flight and queued commands; no res_valid pulse produced for them.

Structure
REQ-031 Package alu_pkg holds opcode constants, FSM state enum, DATA_W=4, SEL_W=4.
REQ-032 Command storage is a sub-module alu_cmd_fifo (width 12, depth FIFO_DEPTH, full/empty/count outputs).

Verification
REQ-033 ADD a=9 b=8, res_ready=1 -> res_valid after 2 edges, res_data=1, res_carry=1, res_err=0.
REQ-034 DIV a=7 b=0 -> res_data=0, res_err=1, res_carry=0; then DIV a=7 b=2 -> res_err=0, res_data=ALU value.
REQ-035 res_ready=0, stream 6 commands -> 5 accepted (1 in HOLD, 4 in FIFO), cmd_ready=0 on 6th; res_* stable throughout.
REQ-036 res_ready=1, 8 back-to-back commands -> 8 results in order, res_valid every other cycle, busy drops 1 cycle after last handshake.
REQ-037 Assert rst_n low while in DRIVE with 3 queued -> all outputs 0 immediately; after release no res_valid until new command.
REQ-038 SUB a=3 b=5 -> res_carry=0 regardless of alu_carry; res_sel=1.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared definitions for the ALU command sequencer: datapath
//            widths, opcode encodings, FSM state type and the packed
//            command record stored in the command FIFO.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package alu_pkg;

    localparam int DATA_W = 4;
    localparam int SEL_W  = 4;
    localparam int CMD_W  = SEL_W + 2 * DATA_W;

    localparam logic [SEL_W-1:0] OP_ADD  = 4'd0;
    localparam logic [SEL_W-1:0] OP_SUB  = 4'd1;
    localparam logic [SEL_W-1:0] OP_MUL  = 4'd2;
    localparam logic [SEL_W-1:0] OP_DIV  = 4'd3;
    localparam logic [SEL_W-1:0] OP_LSL  = 4'd4;
    localparam logic [SEL_W-1:0] OP_LSR  = 4'd5;
    localparam logic [SEL_W-1:0] OP_ROL  = 4'd6;
    localparam logic [SEL_W-1:0] OP_ROR  = 4'd7;
    localparam logic [SEL_W-1:0] OP_AND  = 4'd8;
    localparam logic [SEL_W-1:0] OP_OR   = 4'd9;
    localparam logic [SEL_W-1:0] OP_XOR  = 4'd10;
    localparam logic [SEL_W-1:0] OP_NOR  = 4'd11;
    localparam logic [SEL_W-1:0] OP_NAND = 4'd12;
    localparam logic [SEL_W-1:0] OP_XNOR = 4'd13;
    localparam logic [SEL_W-1:0] OP_GT   = 4'd14;
    localparam logic [SEL_W-1:0] OP_EQ   = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // Layout of one FIFO entry: opcode in the top nibble, then A, then B.
    typedef struct packed {
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } cmd_t;

endpackage
`default_nettype wire

// File: rtl/alu_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : alu_cmd_fifo
// Purpose  : Synchronous single-clock FIFO holding pending ALU commands.
//            Pushes while full and pops while empty are ignored.
// Ports    : clk, rst_n            clock, asynchronous active-low reset
//            push, push_data       write request / entry
//            pop, pop_data         read request / head entry (show-ahead)
//            full, empty, count    occupancy status
// Revision : 1.0  initial release
// ============================================================================
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 12
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int            AW     = $clog2(DEPTH);
    localparam logic [AW:0]   C_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push   = push && !full;
    assign w_pop    = pop && !empty;
    assign full     = (r_count == C_FULL);
    assign empty    = (r_count == '0);
    assign count    = r_count;
    assign pop_data = r_mem[r_rd_ptr];

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_cmd_seq
// Purpose  : Queues ALU commands, drives them one at a time onto an external
//            combinational 4-bit ALU, captures each result and presents it
//            on a valid/ready result interface in acceptance order.
// Ports    : clk, rst_n                      clock, async active-low reset
//            cmd_valid/cmd_ready             command handshake
//            cmd_a, cmd_b, cmd_sel           command operands / opcode
//            alu_a, alu_b, alu_sel           registered drive to the ALU
//            alu_out, alu_carry              ALU result inputs
//            res_valid/res_ready             result handshake
//            res_data, res_carry, res_err    captured result and flags
//            res_sel                         opcode of the captured result
//            busy                            work in flight or queued
// Revision : 1.0  initial release
// ============================================================================
module alu_cmd_seq
    import alu_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [SEL_W-1:0]  cmd_sel,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [SEL_W-1:0]  alu_sel,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_carry,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_carry,
    output logic              res_err,
    output logic [SEL_W-1:0]  res_sel,
    output logic              busy
);

    state_t                     r_state;
    state_t                     w_next;
    logic                       r_live;
    logic                       w_push;
    logic                       w_pop;
    logic                       w_capture;
    logic                       w_release;
    logic                       w_full;
    logic                       w_empty;
    logic [$clog2(FIFO_DEPTH):0] w_count;
    logic [CMD_W-1:0]           w_head_bits;
    cmd_t                       w_head;
    logic                       w_div0;

    // r_live keeps cmd_ready low for as long as reset is asserted and
    // releases it on the first clock after reset is removed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live <= 1'b0;
        end else begin
            r_live <= 1'b1;
        end
    end

    // No bypass: readiness depends only on the registered FIFO occupancy.
    assign cmd_ready = r_live && !w_full;
    assign w_push    = cmd_valid && cmd_ready;
    assign w_head    = cmd_t'(w_head_bits);
    assign busy      = (r_state != ST_IDLE) || (w_count != '0);

    alu_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .push_data ({cmd_sel, cmd_a, cmd_b}),
        .pop       (w_pop),
        .pop_data  (w_head_bits),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // res_valid is high throughout HOLD, so a handshake there is res_ready.
    always_comb begin
        w_next    = r_state;
        w_pop     = 1'b0;
        w_capture = 1'b0;
        w_release = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop  = 1'b1;
                    w_next = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                w_capture = 1'b1;
                w_next    = ST_HOLD;
            end
            ST_HOLD: begin
                if (res_ready) begin
                    w_release = 1'b1;
                    if (!w_empty) begin
                        w_pop  = 1'b1;
                        w_next = ST_DRIVE;
                    end else begin
                        w_next = ST_IDLE;
                    end
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Operand registers change only when a command is popped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a   <= '0;
            alu_b   <= '0;
            alu_sel <= '0;
        end else if (w_pop) begin
            alu_a   <= w_head.a;
            alu_b   <= w_head.b;
            alu_sel <= w_head.sel;
        end
    end

    assign w_div0 = (alu_sel == OP_DIV) && (alu_b == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_carry <= 1'b0;
            res_err   <= 1'b0;
            res_sel   <= '0;
        end else begin
            if (w_capture) begin
                res_valid <= 1'b1;
                res_sel   <= alu_sel;
                res_err   <= w_div0;
                res_data  <= w_div0 ? '0 : alu_out;
                // Carry is only meaningful for addition.
                res_carry <= (alu_sel == OP_ADD) ? alu_carry : 1'b0;
            end else if (w_release) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_cmd_seq
// Purpose  : Directed self-checking bench for alu_cmd_seq with a behavioural
//            model of the external 4-bit ALU.
// Ports    : none
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_cmd_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_a, cmd_b, cmd_sel;
    logic [3:0] alu_a, alu_b, alu_sel;
    logic [3:0] alu_out;
    logic       alu_carry;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_data;
    logic       res_carry, res_err;
    logic [3:0] res_sel;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_cmd_seq #(.FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_sel   (cmd_sel),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_out   (alu_out),
        .alu_carry (alu_carry),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_carry (res_carry),
        .res_err   (res_err),
        .res_sel   (res_sel),
        .busy      (busy)
    );

    // External ALU model. Carry is deliberately set for SUB/MUL/DIV-by-zero
    // cases so that the sequencer's masking of non-ADD carries is exercised.
    logic [4:0] w5;
    logic [7:0] m8;
    always_comb begin
        alu_out   = 4'd0;
        alu_carry = 1'b0;
        w5        = 5'd0;
        m8        = 8'd0;
        case (alu_sel)
            4'd0:  begin w5 = {1'b0, alu_a} + {1'b0, alu_b}; alu_out = w5[3:0]; alu_carry = w5[4]; end
            4'd1:  begin w5 = {1'b0, alu_a} - {1'b0, alu_b}; alu_out = w5[3:0]; alu_carry = w5[4]; end
            4'd2:  begin m8 = alu_a * alu_b; alu_out = m8[3:0]; alu_carry = |m8[7:4]; end
            4'd3:  begin
                if (alu_b == 4'd0) begin alu_out = 4'hF; alu_carry = 1'b1; end
                else               alu_out = alu_a / alu_b;
            end
            4'd4:  begin alu_out = alu_a << 1; alu_carry = alu_a[3]; end
            4'd5:  begin alu_out = alu_a >> 1; alu_carry = alu_a[0]; end
            4'd6:  alu_out = {alu_a[2:0], alu_a[3]};
            4'd7:  alu_out = {alu_a[0], alu_a[3:1]};
            4'd8:  alu_out = alu_a & alu_b;
            4'd9:  alu_out = alu_a | alu_b;
            4'd10: alu_out = alu_a ^ alu_b;
            4'd11: alu_out = ~(alu_a | alu_b);
            4'd12: alu_out = ~(alu_a & alu_b);
            4'd13: alu_out = ~(alu_a ^ alu_b);
            4'd14: alu_out = {3'd0, alu_a > alu_b};
            default: alu_out = {3'd0, alu_a == alu_b};
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [3:0] sel);
        int g;
        g = 0;
        cmd_a = a; cmd_b = b; cmd_sel = sel; cmd_valid = 1'b1;
        while (!cmd_ready && g < 40) begin
            step();
            g++;
        end
        if (!cmd_ready) check("send_timeout", {31'd0, cmd_ready}, 32'd1);
        step();
        cmd_valid = 1'b0;
    endtask

    // Waits (bounded) for res_valid and checks all result fields; g returns
    // the number of cycles waited.
    task automatic expect_res(input string tag, input logic [3:0] d, input logic c,
                              input logic e, input logic [3:0] s, output int g);
        g = 0;
        while (!res_valid && g < 40) begin
            step();
            g++;
        end
        check({tag, "_valid"}, {31'd0, res_valid}, 32'd1);
        check({tag, "_data"},  {28'd0, res_data},  {28'd0, d});
        check({tag, "_carry"}, {31'd0, res_carry}, {31'd0, c});
        check({tag, "_err"},   {31'd0, res_err},   {31'd0, e});
        check({tag, "_sel"},   {28'd0, res_sel},   {28'd0, s});
    endtask

    logic [3:0] v_a [8];
    logic [3:0] v_b [8];
    logic [3:0] v_s [8];
    logic [3:0] v_d [8];
    logic       v_c [8];

    initial begin
        int   g;
        logic seen;

        // ADD 15+1 -> 0 c1; SUB 3-5 -> 14; MUL 6*3 -> 2 (ALU carry masked);
        // LSL 9 -> 2; ROL 9 -> 3; XOR 12^10 -> 6; GT 5>3 -> 1; ROR 1 -> 8
        v_a = '{4'd15, 4'd3, 4'd6, 4'd9, 4'd9, 4'd12, 4'd5, 4'd1};
        v_b = '{4'd1,  4'd5, 4'd3, 4'd0, 4'd0, 4'd10, 4'd3, 4'd0};
        v_s = '{4'd0,  4'd1, 4'd2, 4'd4, 4'd6, 4'd10, 4'd14, 4'd7};
        v_d = '{4'd0,  4'd14, 4'd2, 4'd2, 4'd3, 4'd6, 4'd1, 4'd8};
        v_c = '{1'b1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        // ---- reset state ----
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_a = 4'd0; cmd_b = 4'd0; cmd_sel = 4'd0;
        res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("rst_outputs", {res_valid, res_data, res_carry, res_err, res_sel,
                              alu_a, alu_b, alu_sel, busy}, 32'd0);
        rst_n = 1'b1;
        step();
        check("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // ---- ADD 9+8: latency and carry ----
        res_ready = 1'b1;
        cmd_a = 4'd9; cmd_b = 4'd8; cmd_sel = 4'd0; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        check("add_n0_valid", {31'd0, res_valid}, 32'd0);
        step();
        check("add_n1_valid", {31'd0, res_valid}, 32'd0);
        check("add_n1_alu", {20'd0, alu_a, alu_b, alu_sel}, {20'd0, 4'd9, 4'd8, 4'd0});
        step();
        check("add_n2_valid", {31'd0, res_valid}, 32'd1);
        check("add_data", {28'd0, res_data}, 32'd1);
        check("add_carry", {31'd0, res_carry}, 32'd1);
        check("add_err", {31'd0, res_err}, 32'd0);
        step();
        check("add_done_valid", {31'd0, res_valid}, 32'd0);
        check("add_done_busy", {31'd0, busy}, 32'd0);
        check("idle_alu_retained", {20'd0, alu_a, alu_b, alu_sel}, {20'd0, 4'd9, 4'd8, 4'd0});

        // ---- DIV by zero, then normal DIV ----
        send(4'd7, 4'd0, 4'd3);
        expect_res("div0", 4'd0, 1'b0, 1'b1, 4'd3, g);
        step();
        send(4'd7, 4'd2, 4'd3);
        expect_res("div72", 4'd3, 1'b0, 1'b0, 4'd3, g);
        step();

        // ---- SUB: ALU carry high but must be masked ----
        send(4'd3, 4'd5, 4'd1);
        expect_res("sub35", 4'd14, 1'b0, 1'b0, 4'd1, g);
        step();

        // ---- backpressure: 6 offered, 5 accepted ----
        res_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cmd_a = 4'(i); cmd_b = 4'd3; cmd_sel = 4'd0; cmd_valid = 1'b1;
            check($sformatf("fill_ready_%0d", i), {31'd0, cmd_ready}, (i < 5) ? 32'd1 : 32'd0);
            step();
        end
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("hold_stable", {26'd0, res_valid, res_data, res_err},
                  {26'd0, 1'b1, 4'd3, 1'b0});
            check("hold_full", {31'd0, cmd_ready}, 32'd0);
            step();
        end
        res_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            expect_res($sformatf("drain_%0d", i), 4'(i + 3), 1'b0, 1'b0, 4'd0, g);
            step();
        end
        check("drain_busy", {31'd0, busy}, 32'd0);
        check("drain_no_extra", {31'd0, res_valid}, 32'd0);

        // ---- streaming 8 commands with res_ready high ----
        fork
            begin
                for (int i = 0; i < 8; i++) send(v_a[i], v_b[i], v_s[i]);
            end
            begin
                int w;
                for (int k = 0; k < 8; k++) begin
                    expect_res($sformatf("stream_%0d", k), v_d[k], v_c[k], 1'b0, v_s[k], w);
                    if (k > 0) check($sformatf("stream_gap_%0d", k), w, 32'd1);
                    step();
                end
                check("stream_busy_drop", {31'd0, busy}, 32'd0);
            end
        join

        // ---- reset while driving with 3 queued ----
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(4'(i), 4'd1, 4'd0);
        check("pre_rst_full", {31'd0, cmd_ready}, 32'd0);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("pre_rst_drive", {27'd0, busy, alu_a}, {27'd0, 1'b1, 4'd1});
        check("pre_rst_valid", {31'd0, res_valid}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_outputs", {res_valid, res_data, res_carry, res_err, res_sel,
                                  alu_a, alu_b, alu_sel, busy}, 32'd0);
        check("mid_rst_ready", {31'd0, cmd_ready}, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        res_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            seen = seen | res_valid;
        end
        check("rst_no_spurious", {31'd0, seen}, 32'd0);
        check("rst_release_idle", {30'd0, busy, cmd_ready}, {30'd0, 1'b0, 1'b1});
        send(4'd12, 4'd10, 4'd12);
        expect_res("post_rst_nand", 4'd7, 1'b0, 1'b0, 4'd12, g);
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
